// File: rtl/pc_sequencer_pkg.sv
// Purpose: shared encodings and condition evaluation for the PC sequencer.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package pc_seq_pkg;

  // Sequencing operations; 101-111 are reserved and decode as NEXT
  localparam logic [2:0] OP_NEXT   = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  // Branch condition selects
  localparam logic [2:0] CC_AL = 3'b000;
  localparam logic [2:0] CC_Z  = 3'b001;
  localparam logic [2:0] CC_N  = 3'b010;
  localparam logic [2:0] CC_C  = 3'b011;
  localparam logic [2:0] CC_V  = 3'b100;
  localparam logic [2:0] CC_NZ = 3'b101;
  localparam logic [2:0] CC_NN = 3'b110;
  localparam logic [2:0] CC_LT = 3'b111;

  // Evaluate a branch condition against the live status flags
  function automatic logic cond_true(input logic [2:0] cc, input logic v,
                                     input logic c, input logic n, input logic z);
    logic r;
    r = 1'b0;
    case (cc)
      CC_AL:   r = 1'b1;
      CC_Z:    r = z;
      CC_N:    r = n;
      CC_C:    r = c;
      CC_V:    r = v;
      CC_NZ:   r = ~z;
      CC_NN:   r = ~n;
      default: r = n ^ v;   // signed less-than
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Purpose: bundle of sequencer controls, status flags and PC/stack outputs.
// Latency: n/a (wires only).
// Backpressure: stall is carried here; the sequencer holds all state while it is high.
interface pc_sequencer_if #(
  parameter int PC_WIDTH    = 16,
  parameter int STACK_DEPTH = 4,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
);
  logic                stall;
  logic [2:0]          op;
  logic [2:0]          cond;
  logic                V;
  logic                C;
  logic                N;
  logic                Z;
  logic [PC_WIDTH-1:0] jump_addr;
  logic [PC_WIDTH-1:0] branch_offset;
  logic [PC_WIDTH-1:0] PC;
  logic                taken;
  logic [DW-1:0]       depth;
  logic                stack_full;
  logic                stack_empty;
  logic                stack_err;

  // Control decoder / datapath side
  modport master (
    output stall, op, cond, V, C, N, Z, jump_addr, branch_offset,
    input  PC, taken, depth, stack_full, stack_empty, stack_err
  );

  // Sequencer side
  modport slave (
    input  stall, op, cond, V, C, N, Z, jump_addr, branch_offset,
    output PC, taken, depth, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Purpose: LIFO of return addresses with occupancy, full and empty.
// Latency: push/pop take effect at the next rising edge; top_data is combinational from state.
// Backpressure: push when full and pop when empty are ignored; the caller owns the policy.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_q;

  assign depth = depth_q;
  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);

  // Occupancy counter; contents need no reset since depth gates visibility
  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q <= '0;
    end else if (push && !full) begin
      depth_q <= depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_q - DW'(1);
    end
  end

  // Write the new entry into the slot just above the current top
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset && push && !full && depth_q == DW'(i)) begin
        mem[i] <= push_data;
      end
    end
  end

  // Select the current top entry
  always_comb begin
    top_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) begin
        top_data = mem[i];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Purpose: program counter with jump, conditional branch and CALL/RET via a return stack.
// Latency: new PC visible one cycle after the op; back-to-back redirects every cycle.
// Backpressure: stall holds PC, stack and error flag and forces taken low.
module pc_sequencer #(
  parameter int                  PC_WIDTH     = 16,
  parameter int                  STACK_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic              clock,
  input logic              reset,
  pc_sequencer_if.slave    bus
);
  import pc_seq_pkg::*;

  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] ret_addr;
  logic [DW-1:0]       depth;
  logic                full;
  logic                empty;
  logic                err_q;
  logic                err_set;
  logic                push;
  logic                pop;
  logic                redirect;
  logic                cc_ok;

  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign cc_ok  = cond_true(bus.cond, bus.V, bus.C, bus.N, bus.Z);

  // Next-PC mux plus stack overflow/underflow policy
  always_comb begin
    pc_nxt   = pc_inc;
    redirect = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
    if (!bus.stall && !reset) begin
      case (bus.op)
        OP_JUMP: begin
          pc_nxt   = bus.jump_addr;
          redirect = 1'b1;
        end
        OP_BRANCH: begin
          if (cc_ok) begin
            pc_nxt   = pc_q + bus.branch_offset;
            redirect = 1'b1;
          end
        end
        OP_CALL: begin
          // The jump happens even when the return address cannot be saved
          pc_nxt   = bus.jump_addr;
          redirect = 1'b1;
          if (full) err_set = 1'b1;
          else      push    = 1'b1;
        end
        OP_RET: begin
          // Underflow falls through to sequential execution
          if (empty) begin
            err_set = 1'b1;
          end else begin
            pop      = 1'b1;
            pc_nxt   = ret_addr;
            redirect = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // PC register and sticky stack error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      err_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q  <= pc_nxt;
      err_q <= err_q | err_set;
    end
  end

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (ret_addr),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  assign bus.PC          = pc_q;
  assign bus.taken       = redirect;
  assign bus.depth       = depth;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: directed self-checking bench for pc_sequencer at PC_WIDTH=16, STACK_DEPTH=4.
// Latency: checks PC one cycle after each op, taken in the same cycle.
// Backpressure: exercises stall holding PC and stack.
module tb_pc_sequencer;
  logic clock;
  logic reset;
  int   n_vec = 0;
  int   n_mis = 0;
  logic taken_s;

  pc_sequencer_if #(.PC_WIDTH(16), .STACK_DEPTH(4)) bus ();

  pc_sequencer #(
    .PC_WIDTH     (16),
    .STACK_DEPTH  (4),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every vector, reports any miscompare
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one op (flags = {V,C,N,Z}), capture taken, then step past the edge
  task automatic do_op(input logic [2:0] o, input logic [2:0] c, input logic [15:0] ja,
                       input logic [15:0] off, input logic [3:0] f);
    bus.stall         = 1'b0;
    bus.op            = o;
    bus.cond          = c;
    bus.jump_addr     = ja;
    bus.branch_offset = off;
    {bus.V, bus.C, bus.N, bus.Z} = f;
    #1 taken_s = bus.taken;
    @(posedge clock);
    #1;
  endtask

  // Independent condition reference
  function automatic logic ref_cond(input logic [2:0] c, input logic [3:0] f);
    logic v, cy, n, z;
    {v, cy, n, z} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return n;
      3'd3: return cy;
      3'd4: return v;
      3'd5: return !z;
      3'd6: return !n;
      default: return (n && !v) || (!n && v);
    endcase
  endfunction

  initial begin
    logic [15:0] exp_pc;
    logic        exp_tk;
    bus.stall = 1'b0; bus.op = 3'd0; bus.cond = 3'd0;
    bus.V = 1'b0; bus.C = 1'b0; bus.N = 1'b0; bus.Z = 1'b0;
    bus.jump_addr = 16'h0; bus.branch_offset = 16'h0;
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    chk("rst_pc",    bus.PC, 32'h0);
    chk("rst_depth", bus.depth, 32'd0);
    chk("rst_empty", bus.stack_empty, 32'd1);
    chk("rst_full",  bus.stack_full, 32'd0);
    chk("rst_err",   bus.stack_err, 32'd0);
    reset = 1'b0;

    // Three sequential steps
    do_op(3'b000, 3'd0, 16'h0, 16'h0, 4'h0); chk("next1", bus.PC, 32'h1);
    do_op(3'b000, 3'd0, 16'h0, 16'h0, 4'h0); chk("next2", bus.PC, 32'h2);
    do_op(3'b000, 3'd0, 16'h0, 16'h0, 4'h0); chk("next3", bus.PC, 32'h3);
    chk("next_err", bus.stack_err, 32'd0);

    // Backward branch on Z
    do_op(3'b001, 3'd0, 16'h0010, 16'h0, 4'h0);
    chk("jump_tk", taken_s, 32'd1); chk("jump_pc", bus.PC, 32'h0010);
    do_op(3'b010, 3'd1, 16'h0, 16'hFFFC, 4'b0001);
    chk("brz_tk", taken_s, 32'd1); chk("brz_pc", bus.PC, 32'h000C);
    do_op(3'b001, 3'd0, 16'h0010, 16'h0, 4'h0);
    do_op(3'b010, 3'd1, 16'h0, 16'hFFFC, 4'b0000);
    chk("brnz_tk", taken_s, 32'd0); chk("brnz_pc", bus.PC, 32'h0011);

    // Reserved op behaves as NEXT
    do_op(3'b111, 3'd0, 16'h4444, 16'h0, 4'h0);
    chk("rsv_tk", taken_s, 32'd0); chk("rsv_pc", bus.PC, 32'h0012);

    // Condition sweep over every cond and flag combination
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 16; f++) begin
        do_op(3'b001, 3'd0, 16'h0020, 16'h0, 4'h0);
        do_op(3'b010, 3'(c), 16'h0, 16'h0008, 4'(f));
        exp_tk = ref_cond(3'(c), 4'(f));
        exp_pc = exp_tk ? 16'h0028 : 16'h0021;
        chk($sformatf("cc%0d_f%0h_pc", c, f), bus.PC, 32'(exp_pc));
        chk($sformatf("cc%0d_f%0h_tk", c, f), taken_s, 32'(exp_tk));
      end
    end
    // Signed less-than with N=1, V=0
    do_op(3'b001, 3'd0, 16'h0020, 16'h0, 4'h0);
    do_op(3'b010, 3'd7, 16'h0, 16'h0008, 4'b0010);
    chk("lt_pc", bus.PC, 32'h0028);

    // Nested calls up to and beyond capacity
    do_op(3'b001, 3'd0, 16'h0100, 16'h0, 4'h0);
    do_op(3'b011, 3'd0, 16'h0200, 16'h0, 4'h0); chk("call1_pc", bus.PC, 32'h0200);
    chk("call1_depth", bus.depth, 32'd1);
    do_op(3'b011, 3'd0, 16'h0300, 16'h0, 4'h0);
    do_op(3'b011, 3'd0, 16'h0400, 16'h0, 4'h0);
    do_op(3'b011, 3'd0, 16'h0500, 16'h0, 4'h0);
    chk("call4_depth", bus.depth, 32'd4);
    chk("call4_full",  bus.stack_full, 32'd1);
    chk("call4_err",   bus.stack_err, 32'd0);
    do_op(3'b011, 3'd0, 16'h0600, 16'h0, 4'h0);
    chk("ovf_tk", taken_s, 32'd1); chk("ovf_pc", bus.PC, 32'h0600);
    chk("ovf_depth", bus.depth, 32'd4); chk("ovf_err", bus.stack_err, 32'd1);
    do_op(3'b100, 3'd0, 16'h0, 16'h0, 4'h0); chk("ret1_pc", bus.PC, 32'h0401);
    chk("ret1_tk", taken_s, 32'd1);
    do_op(3'b100, 3'd0, 16'h0, 16'h0, 4'h0); chk("ret2_pc", bus.PC, 32'h0301);
    do_op(3'b100, 3'd0, 16'h0, 16'h0, 4'h0); chk("ret3_pc", bus.PC, 32'h0201);
    do_op(3'b100, 3'd0, 16'h0, 16'h0, 4'h0); chk("ret4_pc", bus.PC, 32'h0101);
    chk("ret4_empty", bus.stack_empty, 32'd1);

    // Reset clears the error, then underflow sets it
    reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
    chk("rst2_err", bus.stack_err, 32'd0);
    do_op(3'b001, 3'd0, 16'h0050, 16'h0, 4'h0);
    do_op(3'b100, 3'd0, 16'h0, 16'h0, 4'h0);
    chk("unf_pc", bus.PC, 32'h0051); chk("unf_tk", taken_s, 32'd0);
    chk("unf_err", bus.stack_err, 32'd1); chk("unf_depth", bus.depth, 32'd0);
    for (int i = 0; i < 10; i++) do_op(3'b000, 3'd0, 16'h0, 16'h0, 4'h0);
    chk("sticky_err", bus.stack_err, 32'd1); chk("sticky_pc", bus.PC, 32'h005B);
    reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
    chk("rst3_err", bus.stack_err, 32'd0);

    // CALL immediately followed by RET
    do_op(3'b001, 3'd0, 16'h0700, 16'h0, 4'h0);
    do_op(3'b011, 3'd0, 16'h0800, 16'h0, 4'h0);
    do_op(3'b100, 3'd0, 16'h0, 16'h0, 4'h0);
    chk("cr_pc", bus.PC, 32'h0701); chk("cr_depth", bus.depth, 32'd0);

    // Stall holds everything
    do_op(3'b011, 3'd0, 16'h0900, 16'h0, 4'h0);
    bus.stall = 1'b1; bus.op = 3'b001; bus.jump_addr = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_tk", bus.taken, 32'd0);
      @(posedge clock); #1;
      chk("stall_pc", bus.PC, 32'h0900); chk("stall_depth", bus.depth, 32'd1);
    end
    bus.stall = 1'b0;

    // Wrap at the top of the address space
    do_op(3'b001, 3'd0, 16'hFFFF, 16'h0, 4'h0);
    do_op(3'b000, 3'd0, 16'h0, 16'h0, 4'h0);
    chk("wrap_pc", bus.PC, 32'h0000);

    // Reset overrides a CALL presented in the same cycle
    do_op(3'b011, 3'd0, 16'h0A00, 16'h0, 4'h0);
    chk("pre_depth", bus.depth, 32'd2);
    bus.op = 3'b011; bus.jump_addr = 16'h0B00; reset = 1'b1;
    #1 chk("rstcall_tk", bus.taken, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rstcall_pc", bus.PC, 32'h0000); chk("rstcall_depth", bus.depth, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the next-generation Simple Computer datapath. It replaces the fixed 16-bit PC controller with a width-configurable PC, a full eight-way condition set over V/C/N/Z, an explicit stall, and subroutine CALL/RET through a hardware return-address stack of configurable depth. It sits between the control decoder, which supplies op/cond, and instruction memory, which is addressed by PC.

Parameters:
PC_WIDTH, 16, width of PC, jump_addr, branch_offset and stack entries
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_VECTOR, 0, PC value loaded on reset

Ports:
clock  in  1  CPU clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC and stack this cycle; op is ignored
op  in  3  sequencing operation (encodings below)
cond  in  3  branch condition select (used only by BRANCH)
V  in  1  overflow status
C  in  1  carry status
N  in  1  negative status
Z  in  1  zero status
jump_addr  in  PC_WIDTH  absolute target for JUMP/CALL
branch_offset  in  PC_WIDTH  two's-complement offset for BRANCH
PC  out  PC_WIDTH  current program counter (registered)
taken  out  1  combinational: current op redirects PC non-sequentially
depth  out  $clog2(STACK_DEPTH+1)  return-stack occupancy (registered)
stack_full  out  1  depth == STACK_DEPTH
stack_empty  out  1  depth == 0
stack_err  out  1  sticky overflow/underflow flag (registered)

Behaviour:
- Reset (synchronous, highest priority): PC=RESET_VECTOR, depth=0, stack_err=0, stack contents don't-care; stack_empty=1, stack_full=0.
- stall=1 (no reset): PC, depth, stack contents and stack_err hold; taken=0.
- op encodings: 000 NEXT: PC+1. 001 JUMP: jump_addr. 010 BRANCH: PC+branch_offset if cond true, else PC+1. 011 CALL: push PC+1, PC=jump_addr. 100 RET: PC=pop. 101-111 reserved, treated as NEXT.
- cond encodings: 000 always; 001 Z; 010 N; 011 C; 100 V; 101 !Z; 110 !N; 111 N^V (signed less-than).
- All PC arithmetic is modulo 2^PC_WIDTH. branch_offset is sign-interpreted, so 'hFFFF at width 16 gives PC-1. 'hFFFF+1 wraps to 0.
- taken=1 for JUMP, CALL, RET on a non-empty stack, and BRANCH with a true condition. Otherwise 0. Gated by stall and reset.
- Latency: the new PC is visible one cycle after the op is presented. There are no bubbles: back-to-back CALL/RET/BRANCH are legal every cycle.
- CALL with stack_full: jump still taken. The push is discarded, depth is unchanged, and stack_err is set.
- RET with stack_empty: PC=PC+1, depth stays 0, stack_err is set, and taken=0.
- stack_err is cleared only by reset.
- CALL then RET on consecutive cycles returns to the CALL address+1, with no bypass hazard because the push completes before the pop.
- Status flags are sampled in the same cycle as op. They are not registered internally.
- Reset asserted during any op or stall overrides it completely.

Decomposition:
- Package pc_seq_pkg: op encoding constants (OP_NEXT, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET) and cond constants (CC_AL, CC_Z, CC_N, CC_C, CC_V, CC_NZ, CC_NN, CC_LT).
- Sub-module return_stack: a parametrised LIFO of STACK_DEPTH x PC_WIDTH with push/pop, depth, full and empty.
- The top level owns PC, condition evaluation, next-PC mux, overflow/underflow policy and stack_err.

Test Plan:
- Reset then 3 NEXT: PC 0 -> 1 -> 2 -> 3; depth=0; stack_empty=1; stack_err=0.
- PC=0x0010, BRANCH cond=001, Z=1, offset=0xFFFC -> PC=0x000C, taken=1. Same with Z=0 -> PC=0x0011, taken=0.
- Cond sweep at PC=0x0020, offset=0x0008, over all 8 conds and all 16 V/C/N/Z combinations: PC=0x0028 exactly when the condition is true, else 0x0021. Include N=1, V=0 for LT true.
- Nested CALLs from 0x0100 to 0x0200, 0x0300, 0x0400, 0x0500 (DEPTH=4): stack_full=1. A 5th CALL to 0x0600 -> PC=0x0600, depth=4, stack_err=1. Then 4 RETs -> 0x0401, 0x0301, 0x0201, 0x0101.
- RET on an empty stack at PC=0x0050 -> PC=0x0051, stack_err=1, taken=0. stack_err persists through 10 NEXTs; reset clears it.
- stall=1 with JUMP 0x1234 for 3 cycles -> PC and depth unchanged. PC=0xFFFF with NEXT -> 0x0000. Reset asserted mid-CALL -> PC=RESET_VECTOR, depth=0.
